// File: rtl/lcd_pkg.sv
// Shared LCD timing constants (common with the timing driver) and the
// receiver frame-tracking state encoding.
package lcd_pkg;

    localparam logic [10:0] LCD_H_DISP     = 11'd800;
    localparam logic [10:0] LCD_V_DISP     = 11'd480;
    localparam logic [10:0] LCD_H_TOTAL    = 11'd1056;
    localparam logic [10:0] LCD_V_TOTAL    = 11'd525;
    localparam logic [15:0] LCD_VBLANK_MIN = 16'd2000;

    typedef enum logic [1:0] {
        S_SEARCH   = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_ACTIVE   = 2'd2
    } rx_state_e;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/lcd_rgb_rx_if.sv
// LCD input bus plus recovered pixel stream and measurement outputs of lcd_rgb_rx.
// The slave modport is the receiver side; master is the source/observer side.
interface lcd_rgb_rx_if;

    logic        i_lcd_de;
    logic [23:0] i_lcd_rgb;
    logic [23:0] o_pixel_data;
    logic        o_pixel_valid;
    logic [10:0] o_pixel_xpos;
    logic [10:0] o_pixel_ypos;
    logic        o_sof;
    logic        o_eol;
    logic        o_eof;
    logic [10:0] o_meas_width;
    logic [10:0] o_meas_height;
    logic        o_meas_valid;
    logic        o_locked;
    logic        o_fmt_err;

    modport slave (
        input  i_lcd_de, i_lcd_rgb,
        output o_pixel_data, o_pixel_valid, o_pixel_xpos, o_pixel_ypos,
               o_sof, o_eol, o_eof, o_meas_width, o_meas_height,
               o_meas_valid, o_locked, o_fmt_err
    );

    modport master (
        output i_lcd_de, i_lcd_rgb,
        input  o_pixel_data, o_pixel_valid, o_pixel_xpos, o_pixel_ypos,
               o_sof, o_eol, o_eof, o_meas_width, o_meas_height,
               o_meas_valid, o_locked, o_fmt_err
    );

endinterface

// File: rtl/lcd_rgb_rx_meas.sv
// Frame measurement: reference width latch, line counter, width compare,
// lock and format-error generation. Strobes arrive one cycle before the outputs.
module lcd_rx_meas
    import lcd_pkg::*;
#(
    parameter logic [10:0] P_H_DISP = LCD_H_DISP,
    parameter logic [10:0] P_V_DISP = LCD_V_DISP
) (
    input  logic        i_lcd_pclk,
    input  logic        i_rst,
    input  logic        i_sof,
    input  logic        i_eol,
    input  logic        i_eof,
    input  logic [10:0] i_width,
    output logic [10:0] o_meas_width,
    output logic [10:0] o_meas_height,
    output logic        o_meas_valid,
    output logic        o_locked,
    output logic        o_fmt_err
);

    logic [10:0] ref_w_q, ref_w_d;
    logic [10:0] lines_q, lines_d;
    logic        ref_set_q, ref_set_d;
    logic        bad_q, bad_d;
    logic        line_err;
    logic        frame_good;

    // sof restarts the frame in the same cycle, so a width-1 first line
    // both clears and re-latches the reference.
    always_comb begin
        ref_set_d = i_sof ? 1'b0 : ref_set_q;
        bad_d     = i_sof ? 1'b0 : bad_q;
        lines_d   = i_sof ? '0 : lines_q;
        ref_w_d   = ref_w_q;
        line_err  = 1'b0;
        if (i_eol) begin
            lines_d = sat_inc11(lines_d);
            if (!ref_set_d) begin
                ref_w_d   = i_width;
                ref_set_d = 1'b1;
            end else if (i_width != ref_w_q) begin
                line_err = 1'b1;
                bad_d    = 1'b1;
            end
        end
    end

    assign frame_good = (ref_w_q == P_H_DISP) && (lines_q == P_V_DISP) && !bad_q;

    always_ff @(posedge i_lcd_pclk or posedge i_rst) begin
        if (i_rst) begin
            ref_w_q       <= '0;
            lines_q       <= '0;
            ref_set_q     <= 1'b0;
            bad_q         <= 1'b0;
            o_meas_width  <= '0;
            o_meas_height <= '0;
            o_meas_valid  <= 1'b0;
            o_locked      <= 1'b0;
            o_fmt_err     <= 1'b0;
        end else begin
            ref_w_q      <= ref_w_d;
            lines_q      <= lines_d;
            ref_set_q    <= ref_set_d;
            bad_q        <= bad_d;
            o_meas_valid <= i_eof;
            o_fmt_err    <= line_err || (i_eof && !frame_good);
            if (i_eof) begin
                o_meas_width  <= ref_w_q;
                o_meas_height <= lines_q;
                o_locked      <= frame_good;
            end
        end
    end

endmodule

// File: rtl/lcd_rgb_rx.sv
// DE-mode RGB888 LCD receiver: recovers frame/line structure from DE only.
// Optional macro LCD_RX_LOCK_GATE_EN gates pixel valid/sof/eol with o_locked.
module lcd_rgb_rx
    import lcd_pkg::*;
#(
    parameter logic [10:0] P_H_DISP     = LCD_H_DISP,
    parameter logic [10:0] P_V_DISP     = LCD_V_DISP,
    parameter logic [15:0] P_VBLANK_MIN = LCD_VBLANK_MIN
) (
    input  logic        i_lcd_pclk,
    input  logic        i_rst,
    lcd_rgb_rx_if.slave lcd_if
);

    rx_state_e   state_q;
    logic        de1_q;
    logic [23:0] rgb1_q;
    logic [15:0] idle_q, idle_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic        valid_q, sof_q, eol_q, eof_q;
    logic [23:0] data_q;
    logic [10:0] xpos_q, ypos_q;
    logic        pix, sof, eol, eof, vblank, emit, gate, locked;
    logic [10:0] width;

    // Vblank fires on the cycle the idle count reaches P_VBLANK_MIN, always
    // with stage1 DE low so no pixel is lost at the frame boundary.
    assign vblank = !de1_q && (idle_q == P_VBLANK_MIN - 16'd1);
    assign pix    = de1_q && (state_q == S_WAIT_SOF || state_q == S_ACTIVE);
    assign sof    = de1_q && (state_q == S_WAIT_SOF);
    assign eol    = pix && !lcd_if.i_lcd_de;
    assign eof    = vblank && (state_q == S_ACTIVE);
    assign width  = sat_inc11(x_q);

`ifdef LCD_RX_LOCK_GATE_EN
    assign gate = locked;
`else
    assign gate = 1'b1;
`endif
    assign emit = pix && gate;

    always_comb begin
        idle_d = de1_q ? '0 : ((idle_q == '1) ? idle_q : idle_q + 16'd1);
        x_d    = de1_q ? sat_inc11(x_q) : '0;
        y_d    = y_q;
        if (sof)      y_d = eol ? 11'd1 : 11'd0;
        else if (eol) y_d = sat_inc11(y_q);
    end

    always_ff @(posedge i_lcd_pclk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_SEARCH;
            de1_q   <= 1'b0;
            rgb1_q  <= '0;
            idle_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            de1_q  <= lcd_if.i_lcd_de;
            rgb1_q <= lcd_if.i_lcd_rgb;
            idle_q <= idle_d;
            x_q    <= x_d;
            y_q    <= y_d;
            case (state_q)
                S_SEARCH:   if (vblank) state_q <= S_WAIT_SOF;
                S_WAIT_SOF: if (de1_q)  state_q <= S_ACTIVE;
                S_ACTIVE:   if (vblank) state_q <= S_WAIT_SOF;
                default:    state_q <= S_SEARCH;
            endcase
            valid_q <= emit;
            data_q  <= emit ? rgb1_q : '0;
            xpos_q  <= emit ? x_q : '0;
            ypos_q  <= (emit && !sof) ? y_q : '0;
            sof_q   <= sof && gate;
            eol_q   <= eol && gate;
            eof_q   <= eof;
        end
    end

    lcd_rx_meas #(
        .P_H_DISP (P_H_DISP),
        .P_V_DISP (P_V_DISP)
    ) u_meas (
        .i_lcd_pclk    (i_lcd_pclk),
        .i_rst         (i_rst),
        .i_sof         (sof),
        .i_eol         (eol),
        .i_eof         (eof),
        .i_width       (width),
        .o_meas_width  (lcd_if.o_meas_width),
        .o_meas_height (lcd_if.o_meas_height),
        .o_meas_valid  (lcd_if.o_meas_valid),
        .o_locked      (locked),
        .o_fmt_err     (lcd_if.o_fmt_err)
    );

    assign lcd_if.o_locked      = locked;
    assign lcd_if.o_pixel_valid = valid_q;
    assign lcd_if.o_pixel_data  = data_q;
    assign lcd_if.o_pixel_xpos  = xpos_q;
    assign lcd_if.o_pixel_ypos  = ypos_q;
    assign lcd_if.o_sof         = sof_q;
    assign lcd_if.o_eol         = eol_q;
    assign lcd_if.o_eof         = eof_q;

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Scoreboard bench for lcd_rgb_rx: frame-level reference model feeds expected
// pixels and end-of-frame measurements; a negedge monitor pops and compares.
module tb_lcd_rgb_rx;

    localparam int VB = 20;
    localparam int HB = 6;
    localparam int VGAP = 40;

    typedef struct {
        logic [23:0] data;
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        eol;
        logic        err;
        int          cyc;
    } pix_t;

    typedef struct {
        logic [10:0] w;
        logic [10:0] h;
        logic        locked;
    } eof_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    pix_t pix_q[$];
    eof_t eof_q[$];

    // reference model state (frame level)
    int   low_run = 0;
    logic capturing = 1'b0;
    logic armed = 1'b0;
    logic model_locked = 1'b0;
    int   widths[$];
    int   exp_line_errs = 0;
    int   exp_eof_errs = 0;
    int   fmt_pulses = 0;
    logic mon_locked = 1'b0;

    lcd_rgb_rx_if bus();

    lcd_rgb_rx #(
        .P_H_DISP     (11'd8),
        .P_V_DISP     (11'd4),
        .P_VBLANK_MIN (16'd20)
    ) dut (
        .i_lcd_pclk (clk),
        .i_rst      (rst),
        .lcd_if     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input logic de, input logic [23:0] rgb);
        bus.i_lcd_de  = de;
        bus.i_lcd_rgb = rgb;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({bus.o_pixel_data, bus.o_pixel_valid, bus.o_pixel_xpos, bus.o_pixel_ypos,
             bus.o_sof, bus.o_eol, bus.o_eof, bus.o_meas_width, bus.o_meas_height,
             bus.o_meas_valid, bus.o_locked, bus.o_fmt_err} !== '0) begin
            errors++;
            $display("FAIL %s: outputs not all zero (valid=%b data=%h locked=%b mw=%0d mh=%0d), required all 0",
                     name, bus.o_pixel_valid, bus.o_pixel_data, bus.o_locked,
                     bus.o_meas_width, bus.o_meas_height);
        end
    endtask

    task automatic end_frame();
        eof_t e;
        logic same;
        same = 1'b1;
        foreach (widths[i]) if (widths[i] != widths[0]) same = 1'b0;
        e.w = 11'(widths[0]);
        e.h = 11'(widths.size());
        e.locked = (widths[0] == 8) && (widths.size() == 4) && same;
        eof_q.push_back(e);
        model_locked = e.locked;
        if (!e.locked) exp_eof_errs++;
    endtask

    task automatic send_low(input int n);
        if (low_run < VB && low_run + n >= VB) begin
            if (capturing) end_frame();
            capturing = 1'b0;
            armed = 1'b1;
        end
        low_run += n;
        repeat (n) drive(1'b0, 24'($urandom));
    endtask

    // evt: 0 none, 1 release reset before pixel evt_at, 2 async reset pulse at pixel evt_at
    task automatic send_line(input int w, input int evt_at, input int evt);
        int   line_y;
        pix_t p;
        if (armed) begin
            armed = 1'b0;
            capturing = 1'b1;
            widths.delete();
        end
        line_y = widths.size();
        if (capturing) widths.push_back(w);
        low_run = 0;
        for (int i = 0; i < w; i++) begin
            if (i == evt_at && evt == 1) rst = 1'b0;
            if (i == evt_at && evt == 2) begin
                rst = 1'b1;
                #1;
                check_all_zero("async_reset");
                pix_q.delete();
                eof_q.delete();
                capturing = 1'b0;
                armed = 1'b0;
                model_locked = 1'b0;
            end
            p.data = 24'($urandom);
            p.x    = 11'(i);
            p.y    = 11'(line_y);
            p.sof  = (line_y == 0) && (i == 0);
            p.eol  = (i == w - 1);
            p.err  = p.eol && (line_y > 0) && (w != widths[0]);
            p.cyc  = cyc;
            if (capturing) begin
                if (p.err) exp_line_errs++;
`ifdef LCD_RX_LOCK_GATE_EN
                if (model_locked) pix_q.push_back(p);
`else
                pix_q.push_back(p);
`endif
            end
            drive(1'b1, p.data);
            if (i == evt_at && evt == 2) rst = 1'b0;
        end
    endtask

    task automatic send_frame(input int nlines, input int w, input int bad_line, input int bad_w);
        for (int l = 0; l < nlines; l++) begin
            if (l > 0) send_low(HB);
            send_line((l == bad_line) ? bad_w : w, -1, 0);
        end
        send_low(VGAP);
    endtask

    // monitor / scoreboard
    initial begin
        pix_t p;
        eof_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_locked = 1'b0;
                continue;
            end
            if (bus.o_pixel_valid) begin
                checks++;
                if (pix_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel: got x=%0d y=%0d data=%h, required no pixel",
                             bus.o_pixel_xpos, bus.o_pixel_ypos, bus.o_pixel_data);
                end else begin
                    p = pix_q.pop_front();
                    if (bus.o_pixel_data !== p.data || bus.o_pixel_xpos !== p.x ||
                        bus.o_pixel_ypos !== p.y || bus.o_sof !== p.sof ||
                        bus.o_eol !== p.eol || bus.o_fmt_err !== p.err || cyc != p.cyc + 2) begin
                        errors++;
                        $display("FAIL pixel: got d=%h x=%0d y=%0d sof=%b eol=%b err=%b cyc=%0d, required d=%h x=%0d y=%0d sof=%b eol=%b err=%b cyc=%0d",
                                 bus.o_pixel_data, bus.o_pixel_xpos, bus.o_pixel_ypos, bus.o_sof,
                                 bus.o_eol, bus.o_fmt_err, cyc, p.data, p.x, p.y, p.sof, p.eol,
                                 p.err, p.cyc + 2);
                    end
                end
            end else begin
                checks++;
                if ({bus.o_pixel_data, bus.o_pixel_xpos, bus.o_pixel_ypos, bus.o_sof, bus.o_eol} !== '0) begin
                    errors++;
                    $display("FAIL idle_outputs: got d=%h x=%0d y=%0d sof=%b eol=%b, required all 0",
                             bus.o_pixel_data, bus.o_pixel_xpos, bus.o_pixel_ypos, bus.o_sof, bus.o_eol);
                end
            end
            if (bus.o_eof) begin
                checks++;
                if (eof_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_eof: got eof w=%0d h=%0d, required no eof",
                             bus.o_meas_width, bus.o_meas_height);
                end else begin
                    e = eof_q.pop_front();
                    mon_locked = e.locked;
                    if (bus.o_meas_width !== e.w || bus.o_meas_height !== e.h ||
                        bus.o_locked !== e.locked || bus.o_meas_valid !== 1'b1 ||
                        bus.o_fmt_err !== !e.locked) begin
                        errors++;
                        $display("FAIL eof_meas: got w=%0d h=%0d locked=%b mvalid=%b err=%b, required w=%0d h=%0d locked=%b mvalid=1 err=%b",
                                 bus.o_meas_width, bus.o_meas_height, bus.o_locked, bus.o_meas_valid,
                                 bus.o_fmt_err, e.w, e.h, e.locked, !e.locked);
                    end
                end
            end
            checks++;
            if (bus.o_meas_valid !== bus.o_eof || bus.o_locked !== mon_locked) begin
                errors++;
                $display("FAIL hold: got mvalid=%b eof=%b locked=%b, required mvalid=eof locked=%b",
                         bus.o_meas_valid, bus.o_eof, bus.o_locked, mon_locked);
            end
            if (bus.o_fmt_err) fmt_pulses++;
        end
    end

    initial begin
        bus.i_lcd_de  = 1'b0;
        bus.i_lcd_rgb = '0;
        repeat (3) drive(1'b0, 24'($urandom));
        check_all_zero("reset_state");

        // reset released during line 2 of a frame already in progress
        send_line(8, -1, 0);
        low_run = 0;
        repeat (HB) drive(1'b0, 24'($urandom));
        send_line(8, -1, 0);
        low_run = 0;
        repeat (HB) drive(1'b0, 24'($urandom));
        send_line(8, 3, 1);
        send_low(HB);
        send_line(8, -1, 0);
        send_low(VGAP);

        // nominal frames
        repeat (3) send_frame(4, 8, -1, 0);
        // width mismatch on line 3, then recovery
        send_frame(4, 8, 3, 7);
        send_frame(4, 8, -1, 0);
        // height mismatch, then recovery
        send_frame(5, 8, -1, 0);
        send_frame(4, 8, -1, 0);
        // width-1 lines: sof and eol on the same pixel
        send_frame(4, 1, -1, 0);
        send_frame(4, 8, -1, 0);

        // async reset in the middle of line 1, recovery needs a full gap
        send_line(8, -1, 0);
        send_low(HB);
        send_line(8, 4, 2);
        send_low(HB);
        send_line(8, -1, 0);
        send_low(VGAP);
        send_frame(4, 8, -1, 0);
        send_frame(4, 8, -1, 0);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            int nl, w, bl, bw;
            nl = int'($urandom_range(1, 6));
            w  = ($urandom_range(0, 1) == 0) ? 8 : int'($urandom_range(1, 10));
            bl = int'($urandom_range(0, 7));
            bw = int'($urandom_range(1, 10));
            send_frame(nl, w, bl, bw);
        end
        send_frame(4, 8, -1, 0);

        repeat (10) drive(1'b0, 24'($urandom));

        checks++;
        if (pix_q.size() != 0 || eof_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pixels and %0d eofs still expected, required 0 and 0",
                     pix_q.size(), eof_q.size());
        end
        checks++;
        if (fmt_pulses != exp_line_errs + exp_eof_errs) begin
            errors++;
            $display("FAIL fmt_err_count: got %0d pulses, required %0d",
                     fmt_pulses, exp_line_errs + exp_eof_errs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
